// File: rtl/tape_rec_pkg.sv
// Shared types and timing thresholds for the cassette tape recorder.
// Thresholds are in microseconds of measured period between rising edges.
package tape_rec_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    // Below this a period is treated as line noise.
    localparam logic [9:0] TH_BIT1    = 10'd120;
    // From TH_BIT1 up to here a period is a 1 bit.
    localparam logic [9:0] TH_BIT0    = 10'd312;
    // From TH_BIT0 up to here a period is a 0 bit; at or above it is a gap.
    localparam logic [9:0] TH_GAP     = 10'd624;
    // Period counter saturation value (no edge for a long time).
    localparam logic [9:0] PERIOD_MAX = 10'd1023;

endpackage

// File: rtl/tape_period_meter.sv
// Synchronizes the raw tape level, measures the time between rising edges in
// 1 us ticks and classifies each measured period as glitch / bit 1 / bit 0 /
// gap. The first edge after enable or reset only arms the measurement.
module tape_period_meter
    import tape_rec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 24000000
)
(
    input  logic clk_sys,
    input  logic RESET,
    input  logic i_en,
    input  logic i_tape_out,
    output logic o_bit_valid,
    output logic o_bit_val,
    output logic o_glitch,
    output logic o_gap,
    output logic o_sat
);

    localparam int unsigned DIV      = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
    localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_period;
    logic          r_armed;
    logic          r_bit_valid;
    logic          r_bit_val;
    logic          r_glitch;
    logic          r_gap;
    logic          w_rise;
    logic          w_tick;
    logic          w_sat;

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_tick = (r_presc == DIV_LAST);
    assign w_sat  = (r_period == PERIOD_MAX);

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_tape_out;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // 1 us prescaler and saturating period counter, restarted on every edge.
    always_ff @(posedge clk_sys) begin
        if (RESET || !i_en) begin
            r_presc  <= '0;
            r_period <= '0;
        end else if (w_rise) begin
            r_presc  <= '0;
            r_period <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && !w_sat) begin
                r_period <= r_period + 1'b1;
            end
        end
    end

    // Classify the period ending at each edge into one-cycle strobes.
    always_ff @(posedge clk_sys) begin
        if (RESET || !i_en) begin
            r_armed     <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_val   <= 1'b0;
            r_glitch    <= 1'b0;
            r_gap       <= 1'b0;
        end else begin
            r_bit_valid <= 1'b0;
            r_glitch    <= 1'b0;
            r_gap       <= 1'b0;
            if (w_rise) begin
                r_armed <= 1'b1;
                if (r_armed) begin
                    if (r_period < TH_BIT1) begin
                        r_glitch <= 1'b1;
                    end else if (r_period < TH_BIT0) begin
                        r_bit_valid <= 1'b1;
                        r_bit_val   <= 1'b1;
                    end else if (r_period < TH_GAP) begin
                        r_bit_valid <= 1'b1;
                        r_bit_val   <= 1'b0;
                    end else begin
                        r_gap <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_bit_valid = r_bit_valid;
    assign o_bit_val   = r_bit_val;
    assign o_glitch    = r_glitch;
    assign o_gap       = r_gap;
    assign o_sat       = w_sat;

endmodule

// File: rtl/tape_recorder.sv
// Cassette tape recorder: decodes bits from the machine's tape output into
// framed bytes (start 0, 8 data LSB-first, odd parity) and writes them
// sequentially into the tape cache.
module tape_recorder
    import tape_rec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 24000000
)
(
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        en,
    input  logic        tape_out,
    input  logic        rewind,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] tape_len,
    output logic        parity_err,
    output logic        overflow,
    output logic        active,
    output logic [1:0]  o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_shift;
    logic [7:0]  r_wr_data;
    logic [2:0]  r_bit_idx;
    logic        r_par_ok;
    logic [15:0] r_wr_addr;
    logic [15:0] r_tape_len;
    logic        r_parity_err;
    logic        r_overflow;
    logic        w_bit_valid;
    logic        w_bit_val;
    logic        w_glitch;
    logic        w_gap;
    logic        w_sat;
    logic        w_room;

    tape_period_meter #(.CLK_HZ(CLK_HZ)) u_meter (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .i_en        (en),
        .i_tape_out  (tape_out),
        .o_bit_valid (w_bit_valid),
        .o_bit_val   (w_bit_val),
        .o_glitch    (w_glitch),
        .o_gap       (w_gap),
        .o_sat       (w_sat)
    );

    assign w_room = (r_wr_addr != 16'hFFFF);

    // State register.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: framing progress, with motor-off and long silence as aborts.
    always_comb begin
        w_next = r_state;
        if (!en || w_sat) begin
            w_next = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_bit_valid && !w_bit_val) w_next = ST_DATA;
                end
                ST_DATA: begin
                    if (w_glitch || w_gap) w_next = ST_HUNT;
                    else if (w_bit_valid && r_bit_idx == 3'd7) w_next = ST_PARITY;
                end
                ST_PARITY: begin
                    if (w_glitch || w_gap) w_next = ST_HUNT;
                    else if (w_bit_valid) w_next = ST_STORE;
                end
                ST_STORE: w_next = ST_HUNT;
                default:  w_next = ST_HUNT;
            endcase
        end
    end

    // Byte assembly: shift data bits LSB-first, latch byte and parity result.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_par_ok  <= 1'b0;
            r_wr_data <= 8'h00;
        end else begin
            if (r_state == ST_HUNT) begin
                r_bit_idx <= 3'd0;
            end
            if (w_bit_valid && r_state == ST_DATA) begin
                r_shift   <= {w_bit_val, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_bit_valid && r_state == ST_PARITY) begin
                r_par_ok  <= ^{r_shift, w_bit_val};
                r_wr_data <= r_shift;
            end
        end
    end

    // Write pointer, length and sticky flags; rewind wins over a store.
    always_ff @(posedge clk_sys) begin
        if (RESET || rewind) begin
            r_wr_addr    <= 16'h0000;
            r_tape_len   <= 16'h0000;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (r_state == ST_STORE) begin
            if (!r_par_ok) begin
                r_parity_err <= 1'b1;
            end
            if (w_room) begin
                r_wr_addr  <= r_wr_addr + 16'd1;
                r_tape_len <= r_tape_len + 16'd1;
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wr_en       = (r_state == ST_STORE) && w_room && !rewind;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign tape_len    = r_tape_len;
    assign parity_err  = r_parity_err;
    assign overflow    = r_overflow;
    assign active      = (r_state != ST_HUNT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tape_recorder.sv
// Self-checking bench for tape_recorder. Run at CLK_HZ = 1 MHz so one clock
// is one microsecond of tape time. Expected writes go into exp_q as stimulus
// is driven; the write monitor pops and compares on every wr_en.
module tb_tape_recorder;
    import tape_rec_pkg::*;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic        en;
    logic        tape_out;
    logic        rewind;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] tape_len;
    logic        parity_err;
    logic        overflow;
    logic        active;
    logic [1:0]  o_dbg_state;

    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    logic        mon_prev_wr = 1'b0;
    logic [15:0] m_addr;
    logic        use_jitter = 1'b0;
    int          checks = 0;
    int          failures = 0;

    tape_recorder #(.CLK_HZ(1000000)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .en          (en),
        .tape_out    (tape_out),
        .rewind      (rewind),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .tape_len    (tape_len),
        .parity_err  (parity_err),
        .overflow    (overflow),
        .active      (active),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset block
    always #5 clk_sys = ~clk_sys;

    // write monitor: every wr_en must match the oldest expected write
    always @(negedge clk_sys) begin
        if (wr_en) begin
            checks++;
            if (mon_prev_wr) begin
                failures++;
                $display("FAIL wr_en_consecutive got=1 exp=0");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h exp=no write", wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             wr_addr, wr_data, mon_exp[23:8], mon_exp[7:0]);
                end
            end
        end
        mon_prev_wr = wr_en;
    end

    // ---------------- driver tasks ----------------
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic int p1();
        return use_jitter ? int'($urandom_range(140, 290)) : 208;
    endfunction

    function automatic int p0();
        return use_jitter ? int'($urandom_range(330, 600)) : 416;
    endfunction

    // Rising edge now, next rising edge 'us' cycles later.
    task automatic send_period(input int us);
        tape_out = 1'b1;
        repeat (us / 2) @(negedge clk_sys);
        tape_out = 1'b0;
        repeat (us - us / 2) @(negedge clk_sys);
    endtask

    // Arming edge, one bit 1 in HUNT, then the start-bit period.
    task automatic send_leader();
        send_period(p1());
        send_period(p1());
        send_period(p0());
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_period(b[i] ? p1() : p0());
    endtask

    // Full frame; the trailing period's edge delivers the parity bit.
    task automatic send_byte(input logic [7:0] b, input logic par);
        send_leader();
        send_bits(b, 8);
        send_period(par ? p1() : p0());
        send_period(p1());
    endtask

    task automatic pulse_rewind();
        rewind = 1'b1;
        repeat (2) @(negedge clk_sys);
        rewind = 1'b0;
        @(negedge clk_sys);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1; en = 1'b0; tape_out = 1'b0; rewind = 1'b0;
        repeat (4) @(negedge clk_sys);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0000", wr_addr); end
        checks++; if (wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (tape_len !== 16'h0) begin failures++; $display("FAIL reset_tape_len got=%h exp=0000", tape_len); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
        RESET = 1'b0;
        m_addr = 16'h0;
        repeat (2) @(negedge clk_sys);
        en = 1'b1;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic test_good_byte();
        exp_q.push_back({m_addr, 8'h16});
        send_byte(8'h16, odd_par(8'h16));
        m_addr++;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL good_byte_written got pending=%0d exp=0", exp_q.size()); end
        checks++; if (tape_len !== 16'd1) begin failures++; $display("FAIL good_byte_len got=%0d exp=1", tape_len); end
        checks++; if (wr_addr !== 16'd1) begin failures++; $display("FAIL good_byte_addr got=%0d exp=1", wr_addr); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL good_byte_parity got=%b exp=0", parity_err); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL good_byte_active got=%b exp=0", active); end
    endtask

    task automatic test_parity_err();
        exp_q.push_back({m_addr, 8'h16});
        send_byte(8'h16, ~odd_par(8'h16));
        m_addr++;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bad_par_written got pending=%0d exp=0", exp_q.size()); end
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL bad_par_flag got=%b exp=1", parity_err); end
        checks++; if (tape_len !== m_addr) begin failures++; $display("FAIL bad_par_len got=%0d exp=%0d", tape_len, m_addr); end
        pulse_rewind();
        m_addr = 16'h0;
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL rewind_addr got=%h exp=0000", wr_addr); end
        checks++; if (tape_len !== 16'h0) begin failures++; $display("FAIL rewind_len got=%h exp=0000", tape_len); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL rewind_parity got=%b exp=0", parity_err); end
    endtask

    task automatic test_abort_gap();
        send_leader();
        send_bits(8'hC3, 4);
        tape_out = 1'b1;
        repeat (10) @(negedge clk_sys);
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL gap_mid_active got=%b exp=1", active); end
        tape_out = 1'b0;
        repeat (790) @(negedge clk_sys);
        tape_out = 1'b1;
        repeat (10) @(negedge clk_sys);
        tape_out = 1'b0;
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL gap_abort_active got=%b exp=0", active); end
        checks++; if (tape_len !== m_addr) begin failures++; $display("FAIL gap_abort_len got=%0d exp=%0d", tape_len, m_addr); end
        repeat (50) @(negedge clk_sys);
    endtask

    task automatic test_abort_glitch();
        send_leader();
        send_bits(8'h55, 3);
        send_period(60);
        send_period(208);
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL glitch_abort_active got=%b exp=0", active); end
        checks++; if (tape_len !== m_addr) begin failures++; $display("FAIL glitch_abort_len got=%0d exp=%0d", tape_len, m_addr); end
    endtask

    task automatic test_en_drop();
        send_leader();
        send_bits(8'hFF, 2);
        tape_out = 1'b1;
        repeat (8) @(negedge clk_sys);
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL en_mid_active got=%b exp=1", active); end
        en = 1'b0;
        @(negedge clk_sys);
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL en_drop_active got=%b exp=0", active); end
        checks++; if (wr_addr !== m_addr) begin failures++; $display("FAIL en_drop_addr got=%0d exp=%0d", wr_addr, m_addr); end
        tape_out = 1'b0;
        repeat (20) @(negedge clk_sys);
        en = 1'b1;
        repeat (20) @(negedge clk_sys);
    endtask

    task automatic test_rewind_in_store();
        logic found;
        exp_q.push_back({m_addr, 8'h3C});
        send_byte(8'h3C, odd_par(8'h3C));
        m_addr++;
        checks++; if (tape_len !== m_addr) begin failures++; $display("FAIL pre_store_len got=%0d exp=%0d", tape_len, m_addr); end
        found = 1'b0;
        fork
            send_byte(8'h81, odd_par(8'h81));
            begin
                for (int i = 0; i < 6000 && !found; i++) begin
                    @(posedge clk_sys); #1;
                    if (o_dbg_state == ST_STORE) found = 1'b1;
                end
                if (found) begin
                    rewind = 1'b1;
                    #1;
                    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL store_rewind_wr_en got=%b exp=0", wr_en); end
                    @(posedge clk_sys); #1;
                    rewind = 1'b0;
                    m_addr = 16'h0;
                    checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL store_rewind_addr got=%h exp=0000", wr_addr); end
                    checks++; if (tape_len !== 16'h0) begin failures++; $display("FAIL store_rewind_len got=%h exp=0000", tape_len); end
                end else begin
                    checks++; failures++;
                    $display("FAIL store_timeout got=no STORE exp=STORE within 6000 cycles");
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        use_jitter = 1'b1;
        for (int n = 0; n < 2; n++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back({m_addr, b});
            send_byte(b, odd_par(b));
            m_addr++;
        end
        use_jitter = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_written got pending=%0d exp=0", exp_q.size()); end
        checks++; if (tape_len !== m_addr) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", tape_len, m_addr); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL b2b_parity got=%b exp=0", parity_err); end
    endtask

    task automatic test_reset_mid_byte();
        send_leader();
        send_bits(8'h99, 5);
        tape_out = 1'b1;
        repeat (8) @(negedge clk_sys);
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL rst_mid_active got=%b exp=1", active); end
        RESET = 1'b1;
        repeat (3) @(negedge clk_sys);
        tape_out = 1'b0;
        @(negedge clk_sys);
        RESET = 1'b0;
        m_addr = 16'h0;
        @(negedge clk_sys);
        checks++; if (wr_addr !== 16'h0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0000", wr_addr); end
        exp_q.push_back({m_addr, 8'h5A});
        send_byte(8'h5A, odd_par(8'h5A));
        m_addr++;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_mid_written got pending=%0d exp=0", exp_q.size()); end
        checks++; if (tape_len !== 16'd1) begin failures++; $display("FAIL rst_mid_len got=%0d exp=1", tape_len); end
    endtask

    task automatic test_overflow();
        pulse_rewind();
        force dut.r_wr_addr = 16'hFFFE;
        @(negedge clk_sys);
        release dut.r_wr_addr;
        @(negedge clk_sys);
        m_addr = 16'hFFFE;
        checks++; if (wr_addr !== 16'hFFFE) begin failures++; $display("FAIL ovf_preload got=%h exp=fffe", wr_addr); end
        exp_q.push_back({m_addr, 8'hA5});
        send_byte(8'hA5, odd_par(8'hA5));
        checks++; if (wr_addr !== 16'hFFFF) begin failures++; $display("FAIL ovf_first_addr got=%h exp=ffff", wr_addr); end
        checks++; if (tape_len !== 16'd1) begin failures++; $display("FAIL ovf_first_len got=%0d exp=1", tape_len); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_first_flag got=%b exp=0", overflow); end
        send_byte(8'h3C, odd_par(8'h3C));
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_second_flag got=%b exp=1", overflow); end
        checks++; if (tape_len !== 16'd1) begin failures++; $display("FAIL ovf_second_len got=%0d exp=1", tape_len); end
        checks++; if (wr_addr !== 16'hFFFF) begin failures++; $display("FAIL ovf_second_addr got=%h exp=ffff", wr_addr); end
        pulse_rewind();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_rewind_flag got=%b exp=0", overflow); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_good_byte();
        test_parity_err();
        test_abort_gap();
        test_abort_glitch();
        test_en_drop();
        test_rewind_in_store();
        test_back_to_back();
        test_reset_mid_byte();
        test_overflow();
        repeat (10) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue got pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
